// File: rtl/lives_manager_pkg.sv
// Shared game-state definitions: life-count width, default tunables, FSM encoding.
// Pure declarations, no logic or latency.
// No flow control; constants only.
package lives_manager_pkg;

  localparam int LIVES_W           = 2;
  localparam int CNT_W             = 8;
  localparam int DEF_MAX_LIVES     = 3;
  localparam int DEF_INVULN_FRAMES = 60;

  // Encoding is fixed so other game blocks can decode it; 2'd3 is unreachable
  // and treated as a corrupted state that recovers to PLAY.
  typedef enum logic [1:0] {
    ST_PLAY   = 2'd0,
    ST_INVULN = 2'd1,
    ST_OVER   = 2'd2,
    ST_BAD    = 2'd3
  } state_t;

endpackage

// File: rtl/lives_manager_if.sv
// Game-event inputs and HUD/status outputs of the life manager, grouped as one bundle.
// Wires only, no latency.
// No backpressure: events are single-cycle pulses or levels.
interface lives_manager_if;
  import lives_manager_pkg::*;

  logic               frame_tick;
  logic               hit;
  logic               new_game;
  logic [LIVES_W-1:0] lives;
  logic               invulnerable;
  logic               blink;
  logic               respawn;
  logic               game_over;

  modport master (
    output frame_tick, hit, new_game,
    input  lives, invulnerable, blink, respawn, game_over
  );

  modport slave (
    input  frame_tick, hit, new_game,
    output lives, invulnerable, blink, respawn, game_over
  );

endinterface

// File: rtl/lives_manager_frame_countdown.sv
// Generic down-counter with clear, load and tick enable; saturates at zero.
// Count updates one cycle after the control input; last is a decode of the register.
// No backpressure; clear beats load beats tick.
module frame_countdown #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic [W-1:0] count,
  output logic         last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign last = (count == W'(1));

endmodule

// File: rtl/lives_manager.sv
// Owns the player's life count, post-hit invulnerability window, respawn pulse and game-over flag.
// All outputs change one cycle after the triggering input.
// No backpressure: hit is level-sampled, frame_tick/new_game are accepted every cycle.
module lives_manager
  import lives_manager_pkg::*;
#(
  parameter int MAX_LIVES     = DEF_MAX_LIVES,
  parameter int INVULN_FRAMES = DEF_INVULN_FRAMES,
  parameter int BLINK_BIT     = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  lives_manager_if.slave  gi
);

  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(MAX_LIVES);
  localparam logic [CNT_W-1:0]   WIN_INIT   = CNT_W'(INVULN_FRAMES);
  localparam logic [CNT_W-1:0]   BLINK_MASK = CNT_W'(1) << BLINK_BIT;

  state_t             state_q, state_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic               respawn_q, respawn_d;
  logic               invuln_q;
  logic               over_q;

  logic               cnt_clr;
  logic               cnt_load;
  logic               cnt_tick;
  logic [CNT_W-1:0]   cnt;
  logic               cnt_last;

  frame_countdown #(
    .W (CNT_W)
  ) u_countdown (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (WIN_INIT),
    .tick     (cnt_tick),
    .count    (cnt),
    .last     (cnt_last)
  );

  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    respawn_d = 1'b0;
    cnt_clr   = 1'b0;
    cnt_load  = 1'b0;
    cnt_tick  = 1'b0;

    if (gi.new_game) begin
      state_d = ST_PLAY;
      lives_d = LIVES_INIT;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        ST_PLAY: begin
          // lives_q==0 cannot coexist with PLAY, so only >1 and ==1 matter.
          if (gi.hit && (lives_q > LIVES_W'(1))) begin
            lives_d   = lives_q - LIVES_W'(1);
            cnt_load  = 1'b1;
            state_d   = ST_INVULN;
            respawn_d = 1'b1;
          end else if (gi.hit && (lives_q == LIVES_W'(1))) begin
            lives_d   = '0;
            state_d   = ST_OVER;
            respawn_d = 1'b1;
          end
        end
        ST_INVULN: begin
          if (gi.frame_tick) begin
            cnt_tick = 1'b1;
            if (cnt_last) begin
              state_d = ST_PLAY;
            end
          end
        end
        ST_OVER: begin
          lives_d = '0;
        end
        default: begin
          state_d = ST_PLAY;
          lives_d = LIVES_INIT;
          cnt_clr = 1'b1;
        end
      endcase
    end
  end

  // Status flags are flopped from next-state so they switch on the same edge as state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_PLAY;
      lives_q   <= LIVES_INIT;
      respawn_q <= 1'b0;
      invuln_q  <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lives_q   <= lives_d;
      respawn_q <= respawn_d;
      invuln_q  <= (state_d == ST_INVULN);
      over_q    <= (state_d == ST_OVER);
    end
  end

  assign gi.lives        = lives_q;
  assign gi.invulnerable = invuln_q;
  assign gi.blink        = invuln_q & (|(cnt & BLINK_MASK));
  assign gi.respawn      = respawn_q;
  assign gi.game_over    = over_q;

endmodule

// File: tb/tb_lives_manager.sv
// Randomized and directed bench for lives_manager against a frame-level game model.
module tb_lives_manager;

  localparam int MAXL = 3;
  localparam int INV  = 4;
  localparam int BB   = 1;
  localparam int FP   = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lives_manager_if bus ();

  lives_manager #(
    .MAX_LIVES     (MAXL),
    .INVULN_FRAMES (INV),
    .BLINK_BIT     (BB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .gi    (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  // Game model: lives left, frames of protection left, game-over flag, respawn this cycle.
  int m_lives = MAXL;
  int m_win   = 0;
  bit m_over  = 1'b0;
  bit m_resp  = 1'b0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_lives = MAXL;
    m_win   = 0;
    m_over  = 1'b0;
    m_resp  = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".lives"},   int'(bus.lives),        m_lives);
    chk({tag, ".invuln"},  int'(bus.invulnerable), (m_win > 0) ? 1 : 0);
    chk({tag, ".blink"},   int'(bus.blink),        (m_win > 0) ? ((m_win >> BB) & 1) : 0);
    chk({tag, ".respawn"}, int'(bus.respawn),      int'(m_resp));
    chk({tag, ".over"},    int'(bus.game_over),    int'(m_over));
  endtask

  task automatic step(input bit ng, input bit h, input bit ft);
    @(negedge clk);
    bus.new_game   = ng;
    bus.hit        = h;
    bus.frame_tick = ft;
    @(posedge clk);
    m_resp = 1'b0;
    if (ng) begin
      m_lives = MAXL;
      m_win   = 0;
      m_over  = 1'b0;
    end else if (m_over) begin
      // finished game: nothing but new_game matters
    end else if (m_win > 0) begin
      if (ft) m_win--;
    end else if (h && m_lives > 0) begin
      m_lives--;
      m_resp = 1'b1;
      if (m_lives == 0) m_over = 1'b1;
      else              m_win  = INV;
    end
    #1;
    check_all("cyc");
  endtask

  task automatic frames(input int nf, input bit h);
    for (int f = 0; f < nf; f++)
      for (int c = 0; c < FP; c++)
        step(1'b0, h, c == FP - 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int ticks;
    bit held;
    bus.new_game   = 1'b0;
    bus.hit        = 1'b0;
    bus.frame_tick = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Idle play: nothing should move.
    frames(10, 1'b0);

    // Single hit, then count frame ticks until protection ends.
    step(1'b0, 1'b1, 1'b0);
    chk("hit1.lives", int'(bus.lives), 2);
    chk("hit1.respawn", int'(bus.respawn), 1);
    ticks = 0;
    for (int i = 0; i < 20 * FP && bus.invulnerable; i++) begin
      step(1'b0, 1'b0, (i % FP) == FP - 1);
      if ((i % FP) == FP - 1) ticks++;
    end
    chk("invuln_ticks", ticks, INV);
    chk("invuln_end", int'(bus.invulnerable), 0);

    // Held hit drains the remaining lives, one per return to play.
    step(1'b1, 1'b0, 1'b0);
    frames(10, 1'b1);
    chk("held.lives", int'(bus.lives), 0);
    chk("held.over", int'(bus.game_over), 1);

    // Game over ignores hits and ticks.
    for (int i = 0; i < 12; i++) step(1'b0, i[0], i[1]);
    step(1'b1, 1'b0, 1'b0);
    chk("ng.lives", int'(bus.lives), MAXL);
    chk("ng.over", int'(bus.game_over), 0);

    // new_game wins over a simultaneous hit.
    step(1'b0, 1'b1, 1'b0);
    frames(INV + 1, 1'b0);
    chk("pre_ng_hit.lives", int'(bus.lives), 2);
    step(1'b1, 1'b1, 1'b0);
    chk("ng_hit.lives", int'(bus.lives), MAXL);
    chk("ng_hit.respawn", int'(bus.respawn), 0);

    // Async reset with two frames of protection left.
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("mid.invuln", int'(bus.invulnerable), 1);
    bus.hit = 1'b0;
    bus.frame_tick = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("arst");
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("post_rst.lives", int'(bus.lives), 2);

    // Random play: sparse hits (sometimes held), ticks and restarts.
    held = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      bit ng, h, ft;
      if ($urandom_range(0, 40) == 0) held = ~held;
      ng = ($urandom_range(0, 80) == 0);
      h  = held | ($urandom_range(0, 7) == 0);
      ft = ($urandom_range(0, 4) == 0);
      step(ng, h, ft);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
